// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : adder_4bit
// Purpose  : Combinational 4-bit adder slice with carry in and carry out.
// Ports    : a, b     - 4-bit addends
//            carry_in - carry into bit 0
//            sum      - 4-bit sum
//            carry    - carry out of bit 3
// Revision : 1.0 - initial release
// ============================================================================
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};
  assign sum     = w_total[3:0];
  assign carry   = w_total[4];

endmodule

// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : Multi-cycle wide adder that streams one nibble pair per cycle
//            through a single adder_4bit, registering the carry between
//            nibbles. Operands arrive and the result leaves through
//            valid/ready handshakes.
// Ports    : clk, n_rst             - clock, synchronous active-low reset
//            in_valid / in_ready    - operand handshake
//            op_a, op_b, cin        - W-bit operands and carry in
//            out_valid / out_ready  - result handshake
//            result, carry_out, ovf - registered sum, carry, signed overflow
//            busy                   - operation in progress (CALC or DONE)
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4*NUM_NIBBLES-1:0] op_a,
  input  logic [4*NUM_NIBBLES-1:0] op_b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*NUM_NIBBLES-1:0] result,
  output logic                     carry_out,
  output logic                     ovf,
  output logic                     busy
);

  localparam int W     = 4 * NUM_NIBBLES;
  localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic             r_carry;

  logic [W-1:0]     w_a_shift;
  logic [W-1:0]     w_b_shift;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_sum;
  logic             w_nib_carry;

  // Select the active nibble by shifting it down to bit 0.
  assign w_a_shift = r_op_a >> {r_idx, 2'b00};
  assign w_b_shift = r_op_b >> {r_idx, 2'b00};
  assign w_a_nib   = w_a_shift[3:0];
  assign w_b_nib   = w_b_shift[3:0];

  adder_4bit u_adder (
    .a        (w_a_nib),
    .b        (w_b_nib),
    .carry_in (r_carry),
    .sum      (w_sum),
    .carry    (w_nib_carry)
  );

  // Handshake and status outputs are pure decodes of the state register.
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_carry   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op_a  <= op_a;
            r_op_b  <= op_b;
            r_carry <= cin;
            result  <= '0;
            r_idx   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          result[{r_idx, 2'b00} +: 4] <= w_sum;
          r_carry                     <= w_nib_carry;
          r_idx                       <= r_idx + 1'b1;
          if (r_idx == c_last_idx) begin
            carry_out <= w_nib_carry;
            // Overflow: like-signed operands producing an opposite-signed sum.
            ovf       <= (r_op_a[W-1] == r_op_b[W-1]) && (w_sum[3] != r_op_a[W-1]);
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Self-checking bench for nibble_serial_adder (NUM_NIBBLES = 4):
//            directed vector table, backpressure and mid-operation reset
//            sequences, and random operands against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

  localparam int NN = 4;
  localparam int W  = 4 * NN;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         ovf;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.NUM_NIBBLES(NN)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain wide addition; overflow from operand/sum sign rules.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output logic [W-1:0] r, output logic co, output logic ov);
    logic [W:0] t;
    t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    r  = t[W-1:0];
    co = t[W];
    ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endtask

  // Present operands at a quiet point and let the accept edge happen.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    op_a     = a;
    op_b     = b;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    cin      = 1'($urandom);
  endtask

  // Count edges after accept until out_valid; bounded.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 4 * NN + 8) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(NN));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] er, input logic eco,
                        input logic eov, input int bp);
    accept(a, b, c);
    wait_done(tag);
    for (int k = 0; k < bp; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    end
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_carry"}, 32'(carry_out), 32'(eco));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eov));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_result_kept"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic [W-1:0] er, ra, rb;
    logic         eco, eov, rc;
    logic [W-1:0] held;

    vecs[0] = '{a: 16'h1234, b: 16'h1111, c: 1'b0, r: 16'h2345, co: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 16'hFFFF, b: 16'h0001, c: 1'b0, r: 16'h0000, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 16'hFFFF, b: 16'h0000, c: 1'b1, r: 16'h0000, co: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 16'h7FFF, b: 16'h0000, c: 1'b1, r: 16'h8000, co: 1'b0, ov: 1'b1};
    vecs[4] = '{a: 16'h8000, b: 16'h8000, c: 1'b0, r: 16'h0000, co: 1'b1, ov: 1'b1};
    vecs[5] = '{a: 16'h0001, b: 16'h0002, c: 1'b0, r: 16'h0003, co: 1'b0, ov: 1'b0};

    n_rst     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
             vecs[i].r, vecs[i].co, vecs[i].ov, i % 3);
    end

    // Backpressure with in_valid pulsing while DONE
    accept(16'h0F0F, 16'h0101, 1'b0);
    wait_done("bp");
    held = result;
    for (int k = 0; k < 5; k++) begin
      op_a     = $urandom;
      op_b     = $urandom;
      in_valid = k[0];
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'(result), 32'(held));
    end
    chk("bp_result_value", 32'(result), 32'h1010);
    // out_ready and in_valid together in DONE: only the release happens.
    op_a      = 16'h0100;
    op_b      = 16'h0023;
    cin       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    chk("bp_release_result", 32'(result), 32'h1010);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_busy", 32'(busy), 32'd1);
    wait_done("bp_next");
    chk("bp_next_result", 32'(result), 32'h0124);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Mid-operation reset
    accept(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_carry", 32'(carry_out), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < NN + 2; k++) begin
      @(posedge clk);
      #1;
      chk("mrst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op("post_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 0);

    // Random operands against the model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      model(ra, rb, rc, er, eco, eov);
      run_op("rand", ra, rb, rc, er, eco, eov, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
